mmio_responder: RTL and testbench

//  Memory-mapped peripheral responder: the target side of the CPU data-memory bus (Address/Write_data/MemRead/MemWrite).

---
 rtl/mmio_responder_pkg.sv | 42 ++++
 rtl/mmio_responder_seg_scanner.sv | 50 +++++
 rtl/mmio_responder.sv | 111 +++++++++++
 tb/tb_mmio_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register map, TCON bit layout,
// digit-select reset value and the hex-to-segment decoder.
package mmio_responder_pkg;

  localparam logic [2:0] IDX_TH      = 3'd0;
  localparam logic [2:0] IDX_TL      = 3'd1;
  localparam logic [2:0] IDX_TCON    = 3'd2;
  localparam logic [2:0] IDX_LED     = 3'd3;
  localparam logic [2:0] IDX_DISP    = 3'd4;
  localparam logic [2:0] IDX_SYSTICK = 3'd5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [3:0] AN_RESET = 4'b0001;

  // Segments active-high, bit0=a .. bit6=g.
  function automatic logic [6:0] bcd7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mmio_responder_seg_scanner.sv
// Multiplexed 4-digit 7-segment scanner: each digit stays lit SCAN_DIV cycles,
// then the one-hot digit select rotates to the next nibble of disp_i.
module seg_scanner
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] SCAN_DIV = 32'd50000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] disp_i,
  output logic [3:0]  an_o,
  output logic [6:0]  bcd_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  an_q, an_d;
  logic [3:0]  nibble;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    an_d  = an_q;
    if (cnt_q >= SCAN_DIV - 32'd1) begin
      cnt_d = '0;
      an_d  = {an_q[2:0], an_q[3]};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      an_q  <= AN_RESET;
    end else begin
      cnt_q <= cnt_d;
      an_q  <= an_d;
    end
  end

  always_comb begin
    case (an_q)
      4'b0010: nibble = disp_i[7:4];
      4'b0100: nibble = disp_i[11:8];
      4'b1000: nibble = disp_i[15:12];
      default: nibble = disp_i[3:0];
    endcase
  end

  assign an_o  = an_q;
  assign bcd_o = bcd7(nibble);

endmodule

// File: rtl/mmio_responder.sv
// Zero-wait-state MMIO target for the CPU data bus: 32-byte register window
// holding a reloading timer, LED latch, 7-seg display data and a free-running tick.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] SCAN_DIV  = 32'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic        irq,
  output logic [7:0]  led,
  output logic [3:0]  an,
  output logic [6:0]  bcd
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [15:0] disp_q, disp_d;
  logic [31:0] systick_q;

  logic [2:0]  idx;
  logic        wr_en;
  logic        ovf;
  logic        set_st;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign Hit             = (Address[31:5] == BASE_ADDR[31:5]);
  assign idx             = Address[4:2];
  assign wr_en           = Hit & MemWrite;
  assign unused_addr_lsb = &{1'b0, Address[1:0]};

  assign ovf    = tcon_q[TCON_EN] & (tl_q == 32'hFFFF_FFFF);
  assign set_st = ovf & tcon_q[TCON_IE];

  // Timer runs first; a CPU write then overrides its target, except that an
  // overflow-set of ST survives a same-cycle TCON write.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    disp_d = disp_q;
    if (tcon_q[TCON_EN]) tl_d = ovf ? th_q : tl_q + 32'd1;
    tcon_d[TCON_ST] = tcon_q[TCON_ST] | set_st;
    if (wr_en) begin
      case (idx)
        IDX_TH:   th_d   = Write_data;
        IDX_TL:   tl_d   = Write_data;
        IDX_TCON: tcon_d = {Write_data[2] | set_st, Write_data[1:0]};
        IDX_LED:  led_d  = Write_data[7:0];
        IDX_DISP: disp_d = Write_data[15:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      disp_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      disp_q    <= disp_d;
      systick_q <= systick_q + 32'd1;
    end
  end

  always_comb begin
    case (idx)
      IDX_TH:      rdata = th_q;
      IDX_TL:      rdata = tl_q;
      IDX_TCON:    rdata = {29'd0, tcon_q};
      IDX_LED:     rdata = {24'd0, led_q};
      IDX_DISP:    rdata = {16'd0, disp_q};
      IDX_SYSTICK: rdata = systick_q;
      default:     rdata = 32'd0;
    endcase
  end

  assign Read_data = (Hit & MemRead) ? rdata : 32'd0;
  assign irq       = tcon_q[TCON_IE] & tcon_q[TCON_ST];
  assign led       = led_q;

  seg_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk_i  (clk),
    .reset_i(reset),
    .disp_i (disp_q),
    .an_o   (an),
    .bcd_o  (bcd)
  );

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized scoreboard bench for mmio_responder: reads push expected data,
// a negedge monitor pops and compares and also checks led/an/bcd/irq each cycle.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          SDIV = 4;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        Hit;
  logic        irq;
  logic [7:0]  led;
  logic [3:0]  an;
  logic [6:0]  bcd;

  always #5 clk = ~clk;

  mmio_responder #(
    .BASE_ADDR(BASE),
    .SCAN_DIV (32'(SDIV))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Read_data (Read_data),
    .Hit       (Hit),
    .irq       (irq),
    .led       (led),
    .an        (an),
    .bcd       (bcd)
  );

  // Reference model state
  logic [31:0]     m_th = '0, m_tl = '0;
  logic [2:0]      m_tcon = '0;
  logic [7:0]      m_led = '0;
  logic [15:0]     m_disp = '0;
  longint unsigned m_cyc = 0;
  logic [6:0]      seg_lut [16];

  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a & 32'hFFFF_FFE0) == BASE;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!m_hit(a)) return 32'd0;
    case (off / 4)
      0: return m_th;
      1: return m_tl;
      2: return {29'd0, m_tcon};
      3: return {24'd0, m_led};
      4: return {16'd0, m_disp};
      5: return m_cyc[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int m_digit();
    return int'((m_cyc / longint'(SDIV)) % 4);
  endfunction

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_disp = '0; m_cyc = 0;
  endtask

  // One rising edge of the peripheral as described by its register rules.
  task automatic model_step(input logic [31:0] a, input logic [31:0] wd, input logic wr);
    logic [31:0] next_tl;
    logic [2:0]  next_tcon;
    logic        overflow;
    logic [31:0] off;
    if (reset) return;
    overflow  = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    next_tl   = m_tcon[0] ? (overflow ? m_th : m_tl + 32'd1) : m_tl;
    next_tcon = m_tcon;
    if (overflow && m_tcon[1]) next_tcon[2] = 1'b1;
    off = a - BASE;
    if (wr && m_hit(a)) begin
      case (off / 4)
        0: m_th = wd;
        1: next_tl = wd;
        2: next_tcon = {wd[2] | (overflow & m_tcon[1]), wd[1:0]};
        3: m_led = wd[7:0];
        4: m_disp = wd[15:0];
        default: ;
      endcase
    end
    m_tl   = next_tl;
    m_tcon = next_tcon;
    m_cyc++;
  endtask

  // Driver: one bus cycle, inputs applied away from the clock edge.
  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] wd,
                           input logic rd, input logic wr);
    Address    = a;
    Write_data = wd;
    MemRead    = rd;
    MemWrite   = wr;
    if (rd) exp_q.push_back({m_hit(a), m_read(a)});
    @(posedge clk);
    #1;
    model_step(a, wd, wr);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic peek(input string name, input logic [31:0] a,
                      input logic [31:0] exp_data, input logic exp_hit);
    Address = a;
    MemRead = 1'b1;
    #1;
    chk({name, "_data"}, Read_data, exp_data);
    chk({name, "_hit"}, {31'd0, Hit}, {31'd0, exp_hit});
    MemRead = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [3:0]  nib;
    logic [32:0] e;
    nib = 4'((m_disp >> (4 * m_digit())) & 16'hF);
    chk("irq", {31'd0, irq}, {31'd0, m_tcon[1] & m_tcon[2]});
    chk("led", {24'd0, led}, {24'd0, m_led});
    chk("an", {28'd0, an}, 32'(4'b0001 << m_digit()));
    chk("bcd", {25'd0, bcd}, {25'd0, seg_lut[nib]});
    if (MemRead) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_queue: read seen with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_hit", {31'd0, Hit}, {31'd0, e[32]});
        chk("rd_data", Read_data, e[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int          sel;
    seg_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);
    bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_an", {28'd0, an}, 32'h1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    // LED write and readback
    bus_cycle(BASE + 32'h0C, 32'h0000_01A5, 1'b0, 1'b1);
    chk("led_a5", {24'd0, led}, 32'hA5);
    peek("led_rd", BASE + 32'h0C, 32'h0000_00A5, 1'b1);
    bus_cycle(BASE + 32'h0C, 32'd0, 1'b1, 1'b0);

    // Timer reload and interrupt
    bus_cycle(BASE + 32'h00, 32'hFFFF_FFF0, 1'b0, 1'b1);
    bus_cycle(BASE + 32'h04, 32'hFFFF_FFFE, 1'b0, 1'b1);
    bus_cycle(BASE + 32'h08, 32'h0000_0003, 1'b0, 1'b1);
    bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);
    peek("tl_max", BASE + 32'h04, 32'hFFFF_FFFF, 1'b1);
    bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);
    peek("tl_reload", BASE + 32'h04, 32'hFFFF_FFF0, 1'b1);
    peek("tcon_st", BASE + 32'h08, 32'h7, 1'b1);
    chk("irq_set", {31'd0, irq}, 32'd1);

    // Overflow coinciding with a TCON write keeps ST
    bus_cycle(BASE + 32'h08, 32'h3, 1'b0, 1'b1);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    bus_cycle(BASE + 32'h04, 32'hFFFF_FFFE, 1'b0, 1'b1);
    bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);
    bus_cycle(BASE + 32'h08, 32'h3, 1'b0, 1'b1);
    peek("tcon_race", BASE + 32'h08, 32'h7, 1'b1);
    chk("irq_race", {31'd0, irq}, 32'd1);
    bus_cycle(BASE + 32'h08, 32'h3, 1'b0, 1'b1);
    chk("irq_clr2", {31'd0, irq}, 32'd0);

    // Display scan over two full rotations
    bus_cycle(BASE + 32'h10, 32'hFFFF_1234, 1'b0, 1'b1);
    repeat (2 * 4 * SDIV) bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);

    // Window edges and read-only SYSTICK
    peek("out_win", BASE + 32'h20, 32'd0, 1'b0);
    peek("idx6", BASE + 32'h18, 32'd0, 1'b1);
    bus_cycle(BASE + 32'h14, 32'hDEAD_BEEF, 1'b0, 1'b1);
    bus_cycle(BASE + 32'h14, 32'd0, 1'b1, 1'b0);
    bus_cycle(BASE + 32'h1C, 32'h1234_5678, 1'b0, 1'b1);
    bus_cycle(BASE + 32'h1C, 32'd0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 8));
      if (sel == 8) a = ($urandom_range(0, 1) != 0) ? BASE + 32'h20 + $urandom_range(0, 31)
                                                   : $urandom;
      else a = BASE + 32'(sel * 4) + $urandom_range(0, 3);
      if (sel == 1 && $urandom_range(0, 1) != 0) d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else if (sel == 2) d = {$urandom_range(0, 32'h1FFF_FFFF), 3'($urandom_range(0, 7))};
      else d = $urandom;
      case ($urandom_range(0, 3))
        0:       bus_cycle(a, d, 1'b0, 1'b1);
        1, 2:    bus_cycle(a, d, 1'b1, 1'b0);
        default: bus_cycle(a, d, 1'b0, 1'b0);
      endcase
    end

    // Asynchronous reset mid-count
    bus_cycle(BASE + 32'h04, 32'd5, 1'b0, 1'b1);
    bus_cycle(BASE + 32'h08, 32'd1, 1'b0, 1'b1);
    bus_cycle(BASE + 32'h0C, 32'h5A, 1'b0, 1'b1);
    for (int k = 0; k < 4 * SDIV && m_digit() != 2; k++) bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);
    chk("pre_rst_an", {28'd0, an}, 32'h4);
    #1;
    reset = 1'b1;
    Address = BASE + 32'h04;
    MemRead = 1'b1;
    #1;
    chk("arst_tl", Read_data, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_led", {24'd0, led}, 32'd0);
    chk("arst_an", {28'd0, an}, 32'h1);
    chk("arst_bcd", {25'd0, bcd}, 32'h3F);
    MemRead = 1'b0;
    model_reset();
    bus_cycle(BASE + 32'h0C, 32'hFF, 1'b0, 1'b1);
    reset = 1'b0;
    bus_cycle(BASE + 32'h14, 32'd0, 1'b1, 1'b0);
    bus_cycle(BASE + 32'h0C, 32'd0, 1'b1, 1'b0);
    repeat (3) bus_cycle(32'd0, 32'd0, 1'b0, 1'b0);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected reads left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
